hash_seq_ctrl: RTL and testbench
================================

HASH_SEQ_CTRL -- requirements
Module: hash_seq_ctrl

Interface
REQ-001 Parameter HASH_TIMEOUT, default 255; max sysclk cycles to wait for hash_done before abort.
REQ-002 Parameter CHAIN_EN, default 1; 1 = each hash is seeded with the previous result, 0 = always seeded with student_id.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low; ports are sysclk and rst_n.
REQ-004 sysclk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 button_in  in  1  raw, asynchronous push-button level.
REQ-007 tick_5s  in  1  single-cycle update strobe from the clock divider.
REQ-008 student_id  in  16  modified student ID; sampled only in S_START.
REQ-009 hash_start  out  1  single-cycle start pulse to the hasher.
REQ-010 hash_seed  out  16  hasher operand; held stable from hash_start until hash_done.
REQ-011 hash_done  in  1  single-cycle hasher completion strobe.
REQ-012 hash_value  in  16  hasher result; valid only in the hash_done cycle.
REQ-013 D5_out..D1_out  out  4 each  BCD digits of the last hash, D5 = most significant.
REQ-014 enable  out  1  run state toggled by button presses.
REQ-015 busy  out  1  high in every state except S_IDLE.
REQ-016 err  out  1  sticky hasher-timeout flag.

Function
REQ-017 button_in SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized level toggles enable; only one toggle per edge.
REQ-018 FSM states SHALL be S_IDLE, S_START, S_WAIT, S_CONV, S_UPDATE.
REQ-019 S_IDLE -> S_START when tick_5s=1 and enable=1; tick_5s in any other state is ignored, not queued.
REQ-020 S_START SHALL last one cycle: assert hash_start, load hash_seed (student_id on the first run after reset or after a CHAIN_EN=0 cycle, else last hash), clear the timeout counter, go to S_WAIT.
REQ-021 S_WAIT: on hash_done, capture hash_value and go to S_CONV; if the counter reaches HASH_TIMEOUT first, set err, drive all digits 4'hE, and return to S_IDLE.
REQ-022 S_CONV SHALL run a sequential 16-iteration shift-add-3 binary-to-BCD conversion, one iteration per cycle, then go to S_UPDATE.
REQ-023 S_UPDATE SHALL load D5..D1 from the converter in one cycle, then return to S_IDLE; the digits change only here or on timeout.
REQ-024 Latency from hash_done to updated digits SHALL be exactly 18 cycles: 1 capture, 16 convert, 1 update.
REQ-025 Maximum value 65535 SHALL display 6,5,5,3,5; value 0 SHALL display 0,0,0,0,0; each digit is always 0-9 except the 4'hE error code.
REQ-026 A disable (enable 1->0) mid-sequence SHALL NOT abort the sequence; it only blocks the next S_IDLE -> S_START.
REQ-027 hash_done outside S_WAIT SHALL be ignored.
REQ-028 err SHALL clear on the next successful S_UPDATE.

Reset
REQ-029 On rst_n=0, immediately: state S_IDLE, enable 0, err 0, busy 0, hash_start 0, hash_seed 0, digits 0, synchronizer flops 0, chain-valid flag 0.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the 4'hE error-digit constant and the 16-bit ID width.
REQ-031 The converter SHALL be a sub-module bin2bcd_seq with start/done handshake, 16-bit input and five 4-bit outputs.

Verification
REQ-032 Reset, press button, tick_5s, model hasher returns 16'd12345 after 10 cycles -> hash_start pulse with seed = student_id; digits 1,2,3,4,5 exactly 18 cycles after hash_done.
REQ-033 CHAIN_EN=1, two ticks, hasher returns 0x00FF then echoes seed+1 -> second hash_seed = 16'h00FF; digits show 0,0,2,5,6.
REQ-034 Hasher never asserts hash_done -> err=1 and digits E,E,E,E,E at cycle HASH_TIMEOUT after start; busy low the next cycle.
REQ-035 tick_5s during S_CONV, and button released then pressed mid-S_WAIT -> no extra hash_start; enable = 0; the sequence completes.
REQ-036 rst_n low during S_CONV -> all outputs reach reset values without a clock edge; no hash_start until the next enable and tick.
REQ-037 Hash value 65535 and value 0 -> digits 6,5,5,3,5 and 0,0,0,0,0.

Source files
------------

// File: rtl/hash_seq_ctrl_pkg.sv
// hash_seq_ctrl_pkg
// Definitions shared by the hash sequencing controller and its BCD converter:
//   - state_t   : controller FSM state encoding
//   - ERR_DIGIT : digit code shown on every display position after a hasher timeout
//   - ID_W      : width of the student ID, seed and hash values
//   - BCD_W     : width of the five-digit BCD result
//   - add3()    : one digit correction step of the shift-add-3 algorithm
package hash_seq_ctrl_pkg;

    localparam int ID_W  = 16;
    localparam int BCD_W = 20;

    localparam logic [3:0] ERR_DIGIT = 4'hE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CONV,
        S_UPDATE
    } state_t;

    // A digit of 5 or more would overflow past 9 when doubled by the next
    // shift, so 3 is added before the shift.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/hash_seq_ctrl_bin2bcd.sv
// bin2bcd_seq
// Sequential 16-bit binary to 5-digit BCD converter (shift-add-3), one
// iteration per clock, 16 iterations per conversion.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   start  in   load bin and begin a conversion
//   bin    in   16-bit binary value, sampled when start is high
//   done   out  high during the cycle whose closing edge performs the final
//               iteration; d5..d1 hold the result from the following cycle
//   d5..d1 out  BCD digits, d5 most significant
module bin2bcd_seq
    import hash_seq_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ID_W-1:0] bin,
    output logic            done,
    output logic [3:0]      d5,
    output logic [3:0]      d4,
    output logic [3:0]      d3,
    output logic [3:0]      d2,
    output logic [3:0]      d1
);

    logic [ID_W-1:0]  bin_reg;
    logic [BCD_W-1:0] bcd_reg;
    logic [15:0]      adj;
    logic [3:0]       iter_reg;
    logic             running_reg;

    // Only the lower four digits need correction: before the final shift the
    // partial value is at most 32767, so the top digit never reaches 5.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = add3(bcd_reg[gi*4 +: 4]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg     <= '0;
            bcd_reg     <= '0;
            iter_reg    <= '0;
            running_reg <= 1'b0;
        end else if (start) begin
            bin_reg     <= bin;
            bcd_reg     <= '0;
            iter_reg    <= '0;
            running_reg <= 1'b1;
        end else if (running_reg) begin
            bin_reg  <= {bin_reg[ID_W-2:0], 1'b0};
            bcd_reg  <= {bcd_reg[18:16], adj, bin_reg[ID_W-1]};
            iter_reg <= iter_reg + 4'd1;
            if (iter_reg == 4'd15) begin
                running_reg <= 1'b0;
            end
        end
    end

    // Combinational so the controller can leave S_CONV on the same edge as
    // the last shift, keeping capture-to-display at exactly 18 cycles.
    assign done = running_reg && (iter_reg == 4'd15);

    assign d5 = bcd_reg[19:16];
    assign d4 = bcd_reg[15:12];
    assign d3 = bcd_reg[11:8];
    assign d2 = bcd_reg[7:4];
    assign d1 = bcd_reg[3:0];

endmodule

// File: rtl/hash_seq_ctrl.sv
// hash_seq_ctrl
// Periodically launches a hash computation, converts the 16-bit result to
// five BCD digits and displays them. A push button toggles the run enable.
// Ports:
//   sysclk        in   system clock
//   rst_n         in   asynchronous active-low reset
//   button_in     in   raw asynchronous push-button level
//   tick_5s       in   single-cycle update strobe
//   student_id    in   initial seed, sampled in S_START
//   hash_start    out  single-cycle start pulse to the hasher
//   hash_seed     out  hasher operand, stable from hash_start until hash_done
//   hash_done     in   single-cycle hasher completion strobe
//   hash_value    in   hasher result, valid with hash_done
//   D5_out..D1_out out BCD digits of the last hash (D5 most significant)
//   enable        out  run state
//   busy          out  high whenever the FSM is not idle
//   err           out  sticky hasher-timeout flag
module hash_seq_ctrl
    import hash_seq_ctrl_pkg::*;
#(
    parameter int HASH_TIMEOUT = 255,
    parameter int CHAIN_EN     = 1
) (
    input  logic            sysclk,
    input  logic            rst_n,
    input  logic            button_in,
    input  logic            tick_5s,
    input  logic [ID_W-1:0] student_id,
    output logic            hash_start,
    output logic [ID_W-1:0] hash_seed,
    input  logic            hash_done,
    input  logic [ID_W-1:0] hash_value,
    output logic [3:0]      D5_out,
    output logic [3:0]      D4_out,
    output logic [3:0]      D3_out,
    output logic [3:0]      D2_out,
    output logic [3:0]      D1_out,
    output logic            enable,
    output logic            busy,
    output logic            err
);

    localparam int CW = $clog2(HASH_TIMEOUT + 1);

    state_t state_reg, state_next;

    logic             btn_s1_reg, btn_s2_reg, btn_prev_reg, enable_reg;
    logic [CW-1:0]    tmo_cnt_reg;
    logic             timeout_hit;
    logic             conv_start, conv_done;
    logic [ID_W-1:0]  hash_cap_reg, hash_seed_reg;
    logic             hash_start_reg, chain_valid_reg, err_reg;
    logic [BCD_W-1:0] digits_reg, conv_digits;

    // Button synchronizer plus a third flop for rising-edge detection.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_reg   <= 1'b0;
            btn_s2_reg   <= 1'b0;
            btn_prev_reg <= 1'b0;
            enable_reg   <= 1'b0;
        end else begin
            btn_s1_reg   <= button_in;
            btn_s2_reg   <= btn_s1_reg;
            btn_prev_reg <= btn_s2_reg;
            if (btn_s2_reg && !btn_prev_reg) begin
                enable_reg <= !enable_reg;
            end
        end
    end

    // The counter holds cycles elapsed since hash_start went high minus one,
    // so the abort lands exactly HASH_TIMEOUT cycles after the start pulse.
    assign timeout_hit = (tmo_cnt_reg == CW'(HASH_TIMEOUT - 1));

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        conv_start = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (tick_5s && enable_reg) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A completion arriving on the timeout cycle still wins.
                if (hash_done) begin
                    conv_start = 1'b1;
                    state_next = S_CONV;
                end else if (timeout_hit) begin
                    state_next = S_IDLE;
                end
            end
            S_CONV: begin
                if (conv_done) begin
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            hash_start_reg  <= 1'b0;
            hash_seed_reg   <= '0;
            hash_cap_reg    <= '0;
            tmo_cnt_reg     <= '0;
            chain_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
            digits_reg      <= '0;
        end else begin
            hash_start_reg <= 1'b0;
            case (state_reg)
                S_START: begin
                    hash_start_reg <= 1'b1;
                    hash_seed_reg  <= chain_valid_reg ? hash_cap_reg : student_id;
                    tmo_cnt_reg    <= '0;
                end
                S_WAIT: begin
                    if (hash_done) begin
                        hash_cap_reg <= hash_value;
                    end else if (timeout_hit) begin
                        err_reg    <= 1'b1;
                        digits_reg <= {5{ERR_DIGIT}};
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
                    end
                end
                S_UPDATE: begin
                    digits_reg      <= conv_digits;
                    err_reg         <= 1'b0;
                    // Chaining only starts once a hash has completed cleanly.
                    chain_valid_reg <= (CHAIN_EN != 0);
                end
                default: begin
                end
            endcase
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (sysclk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (hash_value),
        .done  (conv_done),
        .d5    (conv_digits[19:16]),
        .d4    (conv_digits[15:12]),
        .d3    (conv_digits[11:8]),
        .d2    (conv_digits[7:4]),
        .d1    (conv_digits[3:0])
    );

    assign hash_start = hash_start_reg;
    assign hash_seed  = hash_seed_reg;
    assign enable     = enable_reg;
    assign err        = err_reg;
    assign busy       = (state_reg != S_IDLE);
    assign D5_out     = digits_reg[19:16];
    assign D4_out     = digits_reg[15:12];
    assign D3_out     = digits_reg[11:8];
    assign D2_out     = digits_reg[7:4];
    assign D1_out     = digits_reg[3:0];

endmodule

// File: tb/tb_hash_seq_ctrl.sv
// tb_hash_seq_ctrl
// Directed bench for hash_seq_ctrl: a hand-driven hasher model returns fixed
// values; digits, seeds, latency, timeout, enable handling and reset are
// compared against hand-computed expectations.
module tb_hash_seq_ctrl;

    localparam int TMO = 30;

    logic        sysclk;
    logic        rst_n;
    logic        button_in;
    logic        tick_5s;
    logic [15:0] student_id;
    logic        hash_start;
    logic [15:0] hash_seed;
    logic        hash_done;
    logic [15:0] hash_value;
    logic [3:0]  D5_out, D4_out, D3_out, D2_out, D1_out;
    logic        enable;
    logic        busy;
    logic        err;
    logic [19:0] digits;

    int checks = 0;
    int errors = 0;
    int starts_seen = 0;
    int s0;
    logic [19:0] prev_bcd;

    hash_seq_ctrl #(
        .HASH_TIMEOUT (TMO),
        .CHAIN_EN     (1)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .button_in  (button_in),
        .tick_5s    (tick_5s),
        .student_id (student_id),
        .hash_start (hash_start),
        .hash_seed  (hash_seed),
        .hash_done  (hash_done),
        .hash_value (hash_value),
        .D5_out     (D5_out),
        .D4_out     (D4_out),
        .D3_out     (D3_out),
        .D2_out     (D2_out),
        .D1_out     (D1_out),
        .enable     (enable),
        .busy       (busy),
        .err        (err)
    );

    assign digits = {D5_out, D4_out, D3_out, D2_out, D1_out};

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
        if (hash_start === 1'b1) starts_seen++;
    endtask

    task automatic press();
        button_in = 1'b1;
        repeat (4) step();
        button_in = 1'b0;
        repeat (3) step();
    endtask

    // One full sequence: tick, start pulse, hasher reply 10 cycles after the
    // start pulse, then digit hold at +17 and update at +18 from capture.
    task automatic run_hash(input logic [15:0] exp_seed, input logic [15:0] value,
                            input logic [19:0] exp_bcd, input bit disturb, input string tag);
        int base;
        tick_5s = 1'b1;
        step();
        tick_5s = 1'b0;
        step();
        chk({tag, ":start"}, 32'(hash_start), 32'd1);
        chk({tag, ":seed"}, 32'(hash_seed), 32'(exp_seed));
        chk({tag, ":busy"}, 32'(busy), 32'd1);
        base = starts_seen;
        for (int i = 1; i <= 9; i++) begin
            if (disturb && i == 1) button_in = 1'b1;
            if (disturb && i == 5) button_in = 1'b0;
            step();
        end
        hash_done  = 1'b1;
        hash_value = value;
        step();
        hash_done  = 1'b0;
        hash_value = 16'hBEEF;
        for (int j = 1; j <= 16; j++) begin
            if (disturb && j == 4) tick_5s = 1'b1;
            if (disturb && j == 5) tick_5s = 1'b0;
            step();
        end
        chk({tag, ":hold"}, 32'(digits), 32'(prev_bcd));
        step();
        chk({tag, ":digits"}, 32'(digits), 32'(exp_bcd));
        chk({tag, ":err"}, 32'(err), 32'd0);
        chk({tag, ":idle"}, 32'(busy), 32'd0);
        chk({tag, ":extra_start"}, 32'(starts_seen - base), 32'd0);
        chk({tag, ":enable"}, 32'(enable), disturb ? 32'd0 : 32'd1);
        $display("txn %s seed=%h value=%0d digits=%h", tag, hash_seed, value, digits);
        prev_bcd = exp_bcd;
    endtask

    initial begin
        rst_n      = 1'b0;
        button_in  = 1'b0;
        tick_5s    = 1'b0;
        student_id = 16'hA5C3;
        hash_done  = 1'b0;
        hash_value = 16'h0000;
        prev_bcd   = 20'h00000;

        #3;
        chk("rst:hash_start", 32'(hash_start), 32'd0);
        chk("rst:hash_seed", 32'(hash_seed), 32'd0);
        chk("rst:digits", 32'(digits), 32'd0);
        chk("rst:enable", 32'(enable), 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:err", 32'(err), 32'd0);
        repeat (3) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        step();

        // Tick with enable low must not start anything.
        tick_5s = 1'b1;
        step();
        tick_5s = 1'b0;
        repeat (3) step();
        chk("disabled:busy", 32'(busy), 32'd0);
        chk("disabled:starts", 32'(starts_seen), 32'd0);

        press();
        chk("press:enable", 32'(enable), 32'd1);

        run_hash(16'hA5C3, 16'd12345, 20'h12345, 1'b0, "first");

        // hash_done while idle is ignored.
        hash_done  = 1'b1;
        hash_value = 16'd9;
        step();
        hash_done = 1'b0;
        repeat (3) step();
        chk("stray_done:busy", 32'(busy), 32'd0);
        chk("stray_done:digits", 32'(digits), 32'h12345);

        run_hash(16'd12345, 16'h00FF, 20'h00255, 1'b0, "chain1");
        run_hash(16'h00FF, 16'h0100, 20'h00256, 1'b0, "chain2");

        // Hasher never answers.
        tick_5s = 1'b1;
        step();
        tick_5s = 1'b0;
        step();
        chk("tmo:start", 32'(hash_start), 32'd1);
        chk("tmo:seed", 32'(hash_seed), 32'h0100);
        repeat (TMO - 1) step();
        chk("tmo:err_early", 32'(err), 32'd0);
        chk("tmo:busy_early", 32'(busy), 32'd1);
        step();
        chk("tmo:err", 32'(err), 32'd1);
        chk("tmo:digits", 32'(digits), 32'hEEEEE);
        chk("tmo:busy", 32'(busy), 32'd0);
        $display("txn timeout err=%b digits=%h", err, digits);
        prev_bcd = 20'hEEEEE;

        run_hash(16'h0100, 16'hFFFF, 20'h65535, 1'b0, "max");
        run_hash(16'hFFFF, 16'h0000, 20'h00000, 1'b0, "zero");
        run_hash(16'h0000, 16'd777, 20'h00777, 1'b1, "disturb");

        s0 = starts_seen;
        tick_5s = 1'b1;
        step();
        tick_5s = 1'b0;
        repeat (4) step();
        chk("after_disable:starts", 32'(starts_seen - s0), 32'd0);
        chk("after_disable:busy", 32'(busy), 32'd0);

        press();
        chk("repress:enable", 32'(enable), 32'd1);

        // Reset asserted mid-conversion, away from any clock edge.
        tick_5s = 1'b1;
        step();
        tick_5s = 1'b0;
        step();
        chk("conv_rst:seed", 32'(hash_seed), 32'd777);
        repeat (9) step();
        hash_done  = 1'b1;
        hash_value = 16'd4321;
        step();
        hash_done = 1'b0;
        repeat (5) step();
        chk("conv_rst:busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("conv_rst:hash_start", 32'(hash_start), 32'd0);
        chk("conv_rst:hash_seed", 32'(hash_seed), 32'd0);
        chk("conv_rst:digits", 32'(digits), 32'd0);
        chk("conv_rst:enable", 32'(enable), 32'd0);
        chk("conv_rst:busy", 32'(busy), 32'd0);
        chk("conv_rst:err", 32'(err), 32'd0);
        $display("txn async_reset busy=%b enable=%b digits=%h", busy, enable, digits);
        repeat (2) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        prev_bcd = 20'h00000;

        s0 = starts_seen;
        tick_5s = 1'b1;
        step();
        tick_5s = 1'b0;
        repeat (4) step();
        chk("post_rst:starts", 32'(starts_seen - s0), 32'd0);

        press();
        run_hash(16'hA5C3, 16'd54321, 20'h54321, 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
